// File: rtl/ram_log_reader_if.sv
// Bundles the RAM read port, the outgoing byte stream and the dump command/status
// signals of ram_log_reader; master is the reader side, slave the environment side.
interface ram_log_reader_if #(
  parameter int RAM_WIDTH = 32,
  parameter int AW        = 15
);
  logic                 i_start;
  logic [AW-1:0]        i_num_words;
  logic                 o_enbl_read;
  logic [AW-1:0]        o_read_adrs;
  logic [RAM_WIDTH-1:0] i_ram_data;
  logic [7:0]           o_byte;
  logic                 o_byte_valid;
  logic                 i_byte_ready;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    input  i_start, i_num_words, i_ram_data, i_byte_ready,
    output o_enbl_read, o_read_adrs, o_byte, o_byte_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_num_words, i_ram_data, i_byte_ready,
    input  o_enbl_read, o_read_adrs, o_byte, o_byte_valid, o_busy, o_done
  );
endinterface

// File: rtl/ram_log_reader.sv
// Walks the logging RAM from address 0, captures each word after the read latency and
// streams it MSB-byte-first over a valid/ready byte interface.
module ram_log_reader #(
    parameter int RAM_WIDTH    = 32,
    parameter int RAM_DEPTH    = 32768,
    parameter int READ_LATENCY = 1
) (
    input logic             clk,
    input logic             i_reset,
    ram_log_reader_if.master bus
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int NB = RAM_WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam logic [1:0]    LAT_LAST  = 2'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, ADDR, SEND, DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        num_q, num_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [1:0]           lat_q, lat_d;
    logic [RAM_WIDTH-1:0] word_q, word_d;

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            num_q      <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            lat_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            lat_q      <= lat_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        lat_d      = '0;
        word_d     = word_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    num_d      = bus.i_num_words;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    state_d    = (bus.i_num_words != '0) ? ADDR : DONE;
                end
            end
            ADDR: begin
                // Address is held READ_LATENCY+1 cycles so data is valid on the exit edge.
                if (lat_q == LAT_LAST) begin
                    word_d     = bus.i_ram_data;
                    byte_cnt_d = '0;
                    state_d    = SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            SEND: begin
                if (bus.i_byte_ready) begin
                    word_d     = word_q << 8;
                    byte_cnt_d = byte_cnt_q + CW'(1);
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (addr_q == num_q - AW'(1)) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            state_d = ADDR;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_enbl_read  = (state_q != IDLE);
        bus.o_read_adrs  = addr_q;
        bus.o_byte_valid = (state_q == SEND);
        bus.o_byte       = (state_q == SEND) ? word_q[RAM_WIDTH-1 -: 8] : 8'h00;
        bus.o_busy       = (state_q != IDLE);
        bus.o_done       = (state_q == DONE);
    end

endmodule

// File: tb/tb_ram_log_reader.sv
// Directed bench for ram_log_reader: one instance with 1-cycle RAM latency, one with
// 2-cycle latency, each fed by a behavioural RAM model.
module tb_ram_log_reader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_log_reader_if #(.RAM_WIDTH(32), .AW(15)) b1 ();
    ram_log_reader_if #(.RAM_WIDTH(32), .AW(15)) b2 ();

    ram_log_reader #(.RAM_WIDTH(32), .RAM_DEPTH(32768), .READ_LATENCY(1)) u1 (
        .clk(clk), .i_reset(rst_n), .bus(b1.master));
    ram_log_reader #(.RAM_WIDTH(32), .RAM_DEPTH(32768), .READ_LATENCY(2)) u2 (
        .clk(clk), .i_reset(rst_n), .bus(b2.master));

    logic [31:0] mem [4096];
    logic [31:0] rd1, rd2a, rd2b;

    always @(posedge clk) begin
        if (b1.o_enbl_read) rd1 <= mem[b1.o_read_adrs[11:0]];
        rd2a <= mem[b2.o_read_adrs[11:0]];
        rd2b <= rd2a;
    end
    assign b1.i_ram_data = rd1;
    assign b2.i_ram_data = rd2b;

    // Observers sample mid-cycle, away from the active edge.
    logic [7:0]  q1 [$];
    logic [7:0]  q2 [$];
    logic [14:0] adr_list2 [$];
    int          done1 = 0, done2 = 0, stall_err = 0, addr_err = 0;
    logic        stall_v = 1'b0;
    logic [7:0]  stall_b = '0;
    logic [14:0] adr_a1 = '0, last_adr1 = '0;

    always @(negedge clk) begin
        if (b1.o_byte_valid && b1.i_byte_ready) q1.push_back(b1.o_byte);
        if (b2.o_byte_valid && b2.i_byte_ready) q2.push_back(b2.o_byte);
        if (b1.o_done) done1 <= done1 + 1;
        if (b2.o_done) done2 <= done2 + 1;
        if (rst_n && stall_v && !(b1.o_byte_valid && b1.o_byte == stall_b))
            stall_err <= stall_err + 1;
        stall_v <= rst_n && b1.o_byte_valid && !b1.i_byte_ready;
        stall_b <= b1.o_byte;
        if (b1.o_enbl_read && !b1.o_byte_valid && !b1.o_done) begin
            adr_a1    <= b1.o_read_adrs;
            last_adr1 <= b1.o_read_adrs;
        end
        if (b1.o_byte_valid && b1.o_read_adrs != adr_a1) addr_err <= addr_err + 1;
        if (b2.o_enbl_read && !b2.o_byte_valid && !b2.o_done) adr_list2.push_back(b2.o_read_adrs);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp12 [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

    initial begin
        int k, base, d0, bad;
        logic [31:0] w;
        for (int unsigned i = 0; i < 4096; i++) mem[i] = {16'(i) ^ 16'h5A5A, ~16'(i)};
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        mem[2] = 32'h99AABBCC;
        mem[3] = 32'hDEADBEEF;

        rst_n = 1'b0;
        b1.i_start = 1'b0; b1.i_num_words = '0; b1.i_byte_ready = 1'b1;
        b2.i_start = 1'b0; b2.i_num_words = '0; b2.i_byte_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_enbl", b1.o_enbl_read, 0);
        chk("rst_adrs", b1.o_read_adrs, 0);
        chk("rst_byte", b1.o_byte, 0);
        chk("rst_valid", b1.o_byte_valid, 0);
        chk("rst_busy", b1.o_busy, 0);
        chk("rst_done", b1.o_done, 0);
        chk("rst_busy2", b2.o_busy, 0);

        // Basic 3-word dump, ready held high
        base = q1.size(); d0 = done1;
        b1.i_num_words = 15'd3; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        chk("basic_c1_busy", b1.o_busy, 1);
        chk("basic_c1_enbl", b1.o_enbl_read, 1);
        chk("basic_c1_adrs", b1.o_read_adrs, 0);
        chk("basic_c1_valid", b1.o_byte_valid, 0);
        step();
        chk("basic_c2_valid", b1.o_byte_valid, 0);
        step();
        chk("basic_c3_valid", b1.o_byte_valid, 1);
        chk("basic_c3_byte", b1.o_byte, 8'h11);
        k = 3;
        while (!b1.o_done && k < 100) begin step(); k++; end
        chk("basic_done_cycle", k, 19);
        step();
        chk("basic_nbytes", q1.size() - base, 12);
        for (int i = 0; i < 12; i++) chk("basic_byte", q1[base+i], exp12[i]);
        chk("basic_done_cnt", done1 - d0, 1);
        chk("basic_busy_after", b1.o_busy, 0);
        chk("basic_done_after", b1.o_done, 0);

        // Backpressure: ready follows 1-0-0-1
        base = q1.size(); d0 = done1;
        b1.i_num_words = 15'd3; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        k = 1;
        while (!b1.o_done && k < 200) begin
            b1.i_byte_ready = (k % 4 == 0) || (k % 4 == 3);
            step(); k++;
        end
        b1.i_byte_ready = 1'b1;
        chk("bp_timeout", (k < 200), 1);
        step();
        chk("bp_nbytes", q1.size() - base, 12);
        for (int i = 0; i < 12; i++) chk("bp_byte", q1[base+i], exp12[i]);
        chk("bp_stall_stable", stall_err, 0);
        chk("bp_addr_hold", addr_err, 0);
        chk("bp_done_cnt", done1 - d0, 1);

        // Reset mid-SEND with ready low, then a clean dump
        base = q1.size();
        b1.i_byte_ready = 1'b0; b1.i_num_words = 15'd3; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        k = 1;
        while (!b1.o_byte_valid && k < 20) begin step(); k++; end
        step(); step();
        chk("rstm_stalled_valid", b1.o_byte_valid, 1);
        chk("rstm_stalled_byte", b1.o_byte, 8'h11);
        rst_n = 1'b0;
        step();
        chk("rstm_enbl", b1.o_enbl_read, 0);
        chk("rstm_adrs", b1.o_read_adrs, 0);
        chk("rstm_byte", b1.o_byte, 0);
        chk("rstm_valid", b1.o_byte_valid, 0);
        chk("rstm_busy", b1.o_busy, 0);
        chk("rstm_done", b1.o_done, 0);
        step(); step();
        rst_n = 1'b1; b1.i_byte_ready = 1'b1;
        step();
        chk("rstm_idle_busy", b1.o_busy, 0);
        chk("rstm_no_bytes", q1.size() - base, 0);
        b1.i_num_words = 15'd3; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        chk("rstm_restart_adrs", b1.o_read_adrs, 0);
        k = 1;
        while (!b1.o_done && k < 100) begin step(); k++; end
        chk("rstm_done_cycle", k, 19);
        step();
        chk("rstm_nbytes", q1.size() - base, 12);
        for (int i = 0; i < 12; i++) chk("rstm_byte", q1[base+i], exp12[i]);

        // Empty dump
        base = q1.size(); d0 = done1;
        b1.i_num_words = 15'd0; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        chk("empty_c1_done", b1.o_done, 1);
        chk("empty_c1_enbl", b1.o_enbl_read, 1);
        chk("empty_c1_valid", b1.o_byte_valid, 0);
        step();
        chk("empty_c2_done", b1.o_done, 0);
        chk("empty_c2_busy", b1.o_busy, 0);
        chk("empty_c2_enbl", b1.o_enbl_read, 0);
        chk("empty_nbytes", q1.size() - base, 0);
        chk("empty_done_cnt", done1 - d0, 1);

        // 2-word dump with a second start pulse mid-dump
        base = q1.size(); d0 = done1;
        b1.i_num_words = 15'd2; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        step(); step();
        b1.i_num_words = 15'd5; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        k = 4;
        while (!b1.o_done && k < 100) begin step(); k++; end
        chk("ign_done_cycle", k, 13);
        step(); step();
        chk("ign_nbytes", q1.size() - base, 8);
        for (int i = 0; i < 8; i++) chk("ign_byte", q1[base+i], exp12[i]);
        chk("ign_done_cnt", done1 - d0, 1);
        chk("ign_busy_after", b1.o_busy, 0);

        // READ_LATENCY=2 instance, 4 words
        base = q2.size(); d0 = done2;
        b2.i_num_words = 15'd4; b2.i_start = 1'b1;
        step(); b2.i_start = 1'b0;
        step(); step();
        chk("rl2_c3_valid", b2.o_byte_valid, 0);
        step();
        chk("rl2_c4_valid", b2.o_byte_valid, 1);
        k = 4;
        while (!b2.o_done && k < 100) begin step(); k++; end
        chk("rl2_done_cycle", k, 29);
        step();
        chk("rl2_nbytes", q2.size() - base, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            w = mem[i/4];
            if (q2[base+i] !== w[31 - 8*(i%4) -: 8]) bad++;
        end
        chk("rl2_bytes_bad", bad, 0);
        chk("rl2_addr_cycles", adr_list2.size(), 12);
        for (int i = 0; i < 12; i++) chk("rl2_adrs_seq", adr_list2[i], i/3);
        chk("rl2_done_cnt", done2 - d0, 1);

        // Long dump (2000 words) on the latency-1 instance
        base = q1.size(); d0 = done1;
        b1.i_num_words = 15'd2000; b1.i_start = 1'b1;
        step(); b1.i_start = 1'b0;
        k = 1;
        while (!b1.o_done && k < 13000) begin step(); k++; end
        chk("long_done_cycle", k, 2000*6 + 1);
        step();
        chk("long_last_adrs", last_adr1, 1999);
        chk("long_nbytes", q1.size() - base, 8000);
        bad = 0;
        for (int i = 0; i < 8000; i++) begin
            w = mem[i/4];
            if (q1[base+i] !== w[31 - 8*(i%4) -: 8]) bad++;
        end
        chk("long_bytes_bad", bad, 0);
        chk("long_done_cnt", done1 - d0, 1);
        chk("long_addr_hold", addr_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
